// File: rtl/weight_stream_loader.sv
// weight_stream_loader
//
// Purpose:
//   This is the consumer end of the ap_fifo coefficient channel that the
//   per-layer weight streamers write into. When start is pulsed, the block
//   pops exactly KERN_SIZE coefficients from the FIFO into a local register
//   file. It then raises loaded and serves coefficients to the conv datapath
//   by address, with a one-cycle registered read, which is the same timing as
//   the layer ROMs.
//
// Ports:
//   ap_clk          clock; all state changes on the rising edge
//   ap_rst_n        asynchronous, active-low reset
//   start           single-cycle request to (re)load a kernel
//   input_V_dout    FIFO head data; valid while input_V_empty_n is high
//   input_V_empty_n FIFO holds at least one word
//   input_V_read    pop strobe; a word is consumed on any edge where
//                   input_V_read and input_V_empty_n are both high
//   rd_addr         coefficient address from the datapath
//   rd_ce           read enable
//   rd_q            registered read data
//   busy            a load is in progress
//   loaded          a full kernel is resident and reads are valid

`ifndef coeff_Width
`define coeff_Width 16
`endif

`ifndef kern_s_N
`define kern_s_N 288
`endif

module weight_stream_loader #(
  parameter int COEFF_WIDTH = `coeff_Width,
  parameter int KERN_SIZE   = `kern_s_N,
  localparam int ADDR_W     = $clog2(KERN_SIZE)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   start,
  input  logic [COEFF_WIDTH-1:0] input_V_dout,
  input  logic                   input_V_empty_n,
  output logic                   input_V_read,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_ce,
  output logic [COEFF_WIDTH-1:0] rd_q,
  output logic                   busy,
  output logic                   loaded
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KERN_SIZE - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [COEFF_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                     mem_we;
  logic                     rd_in_range;

  // Kernel storage. It is deliberately left unreset so that it can map onto
  // RAM or register-file primitives.
  logic [COEFF_WIDTH-1:0]   mem [KERN_SIZE];

  // Extend by one bit so the comparison stays correct when KERN_SIZE is a
  // power of two and every address pattern would otherwise be in range.
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(KERN_SIZE));

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    mem_we       = 1'b0;
    input_V_read = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      LOAD: begin
        // Under ap_fifo semantics, read is combinational on empty_n, so a pop
        // and the matching RAM write always happen on the same edge.
        input_V_read = input_V_empty_n;
        if (input_V_empty_n) begin
          mem_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = READY;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      READY: begin
        if (start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        wr_addr_d = '0;
      end
    endcase
  end

  // Reads are honoured only once a complete kernel is resident. Writes occur
  // only in LOAD, so the two ports can never collide. An out-of-range address
  // returns zero.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_ce && (state_q == READY)) begin
      rd_data_d = rd_in_range ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= input_V_dout;
    end
  end

  assign rd_q   = rd_data_q;
  assign busy   = (state_q == LOAD);
  assign loaded = (state_q == READY);

endmodule

// File: tb/tb_weight_stream_loader.sv
// tb_weight_stream_loader
//
// Purpose:
//   Directed and randomized bench for weight_stream_loader with KERN_SIZE=9.
//   The FIFO is a queue that pops only when the DUT strobes read. Expected
//   values come from a kernel-level reference model that tracks how many
//   words have been captured, whether a kernel is resident, and what the
//   read port should hold.

module tb_weight_stream_loader;

  localparam int CW = 16;
  localparam int KS = 9;
  localparam int AW = $clog2(KS);

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          start;
  logic [CW-1:0] input_V_dout;
  logic          input_V_empty_n;
  logic          input_V_read;
  logic [AW-1:0] rd_addr;
  logic          rd_ce;
  logic [CW-1:0] rd_q;
  logic          busy;
  logic          loaded;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] fifo[$];

  // Reference model of the kernel.
  logic [CW-1:0] ref_kernel [KS];
  bit            ref_loading;
  bit            ref_loaded;
  int            ref_count;
  logic [CW-1:0] ref_rdq;

  weight_stream_loader #(
    .COEFF_WIDTH(CW),
    .KERN_SIZE  (KS)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .start          (start),
    .input_V_dout   (input_V_dout),
    .input_V_empty_n(input_V_empty_n),
    .input_V_read   (input_V_read),
    .rd_addr        (rd_addr),
    .rd_ce          (rd_ce),
    .rd_q           (rd_q),
    .busy           (busy),
    .loaded         (loaded)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    ref_loading = 1'b0;
    ref_loaded  = 1'b0;
    ref_count   = 0;
    ref_rdq     = '0;
  endtask

  // One clock cycle. Inputs are driven at the negedge. The read strobe is
  // checked just before the rising edge, and the registered outputs are
  // checked 1 time unit after it.
  task automatic applyStimulus(input bit st, input bit gate, input bit ce, input logic [AW-1:0] addr);
    bit            avail;
    bit            exp_read;
    bit            popped;
    logic [CW-1:0] head;
    @(negedge ap_clk);
    start           = st;
    rd_ce           = ce;
    rd_addr         = addr;
    avail           = gate && (fifo.size() > 0);
    head            = avail ? fifo[0] : CW'($urandom);
    input_V_empty_n = avail;
    input_V_dout    = head;
    #1;
    exp_read = ref_loading && avail;
    popped   = (input_V_read === 1'b1) && avail;
    checkOutput("input_V_read", 32'(input_V_read), 32'(exp_read));
    @(posedge ap_clk);
    #1;
    if (popped) void'(fifo.pop_front());
    if (ce && ref_loaded) ref_rdq = (int'(addr) < KS) ? ref_kernel[addr] : '0;
    if (exp_read) begin
      ref_kernel[ref_count] = head;
      ref_count++;
      if (ref_count == KS) begin
        ref_loading = 1'b0;
        ref_loaded  = 1'b1;
      end
    end else if (st && !ref_loading) begin
      ref_loading = 1'b1;
      ref_loaded  = 1'b0;
      ref_count   = 0;
    end
    checkOutput("busy", 32'(busy), 32'(ref_loading));
    checkOutput("loaded", 32'(loaded), 32'(ref_loaded));
    checkOutput("rd_q", 32'(rd_q), 32'(ref_rdq));
  endtask

  task automatic readAll();
    for (int a = 0; a < KS; a++) applyStimulus(1'b0, 1'b1, 1'b1, AW'(a));
  endtask

  initial begin
    int cycles;
    int zeros;
    ap_rst_n        = 1'b0;
    start           = 1'b0;
    input_V_dout    = '0;
    input_V_empty_n = 1'b0;
    rd_addr         = '0;
    rd_ce           = 1'b0;
    resetModel();

    // Check the state of the outputs while reset is held.
    @(negedge ap_clk);
    @(negedge ap_clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_loaded", 32'(loaded), 32'd0);
    checkOutput("reset_rd_q", 32'(rd_q), 32'd0);
    checkOutput("reset_read", 32'(input_V_read), 32'd0);
    ap_rst_n = 1'b1;

    // Basic load of 1..9, then read every address back.
    $display("[TB] basic load");
    for (int i = 1; i <= KS; i++) fifo.push_back(CW'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < KS; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("basic_busy_window", 32'(busy), (i < KS - 1) ? 32'd1 : 32'd0);
    end
    checkOutput("basic_loaded", 32'(loaded), 32'd1);
    for (int a = 0; a < KS; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, AW'(a));
      checkOutput("basic_rd_value", 32'(rd_q), 32'(a + 1));
    end

    // Bursty FIFO with the pattern 1,0,0 repeated, and random data. Also
    // drive start during the load, which the DUT must ignore.
    $display("[TB] bursty load");
    for (int i = 0; i < KS; i++) fifo.push_back(CW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    cycles = 0;
    zeros  = 0;
    while (loaded !== 1'b1 && cycles < 100) begin
      if (cycles % 3 != 0) zeros++;
      applyStimulus(cycles == 5, cycles % 3 == 0, 1'b0, '0);
      cycles++;
    end
    checkOutput("bursty_latency", 32'(cycles), 32'(KS + zeros));
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b1, AW'($urandom_range(0, 15)));

    // Put 12 words in the FIFO. Exactly 9 must be taken.
    $display("[TB] over-full fifo");
    fifo.delete();
    for (int i = 0; i < 12; i++) fifo.push_back(CW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < KS + 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("fifo_remaining", 32'(fifo.size()), 32'd3);
    readAll();

    // Read an out-of-range address, then hold the result with rd_ce low.
    applyStimulus(1'b0, 1'b1, 1'b1, AW'(9));
    checkOutput("oob_rd_q", 32'(rd_q), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, AW'(3));
    checkOutput("hold_rd_q", 32'(rd_q), 32'd0);

    // Reload with 100..108 while a kernel is resident.
    $display("[TB] reload");
    fifo.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, AW'(2));
    for (int i = 0; i < KS; i++) fifo.push_back(CW'(100 + i));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("reload_loaded_drop", 32'(loaded), 32'd0);
    for (int i = 0; i < KS; i++) applyStimulus(1'b0, 1'b1, 1'b1, AW'($urandom_range(0, 8)));
    applyStimulus(1'b0, 1'b1, 1'b1, AW'(4));
    checkOutput("reload_addr4", 32'(rd_q), 32'd104);
    readAll();

    // Assert reset asynchronously after the 4th pop of a load.
    $display("[TB] reset mid-load");
    fifo.delete();
    for (int i = 0; i < KS; i++) fifo.push_back(CW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_loaded", 32'(loaded), 32'd0);
    checkOutput("async_rd_q", 32'(rd_q), 32'd0);
    checkOutput("async_read", 32'(input_V_read), 32'd0);
    resetModel();
    fifo.delete();
    for (int i = 0; i < KS; i++) fifo.push_back(CW'($urandom));
    @(negedge ap_clk);
    start           = 1'b1;
    input_V_empty_n = 1'b1;
    input_V_dout    = fifo[0];
    #1;
    checkOutput("reset_no_pop", 32'(input_V_read), 32'd0);
    @(posedge ap_clk);
    #1;
    checkOutput("reset_hold_busy", 32'(busy), 32'd0);
    @(negedge ap_clk);
    start    = 1'b0;
    ap_rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < KS; i++) applyStimulus(1'b0, $urandom_range(0, 3) != 0, 1'b0, '0);
    cycles = 0;
    while (!ref_loaded && cycles < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      cycles++;
    end
    checkOutput("fresh_load_done", 32'(loaded), 32'd1);
    readAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
